// File: rtl/cpu_multiciclo.sv
// cpu_multiciclo: multi-cycle load/store CPU with a 16-entry register file.
// Each instruction steps through FETCH, DECODE, EXECUTE, optionally MEM, then
// WRITEBACK. A HALT instruction retires and parks the core in HALT.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   mem_en, mem_we        memory request / write strobe (registered Moore outputs)
//   mem_addr, mem_wdata   word address and store data, held for the whole request
//   mem_rdata, mem_ready  read data and request-complete handshake
//   halted, pc_out        core stopped flag, current PC
//   instret               retired-instruction counter (wraps at 2^32)
//   dbg_raddr, dbg_rdata  combinational debug read of the register file
module cpu_multiciclo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out,
  output logic [31:0]       instret,
  input  logic [3:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  localparam int SH_W = $clog2(DATA_W);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_SAR  = 4'h8;
  localparam logic [3:0] OP_MUL  = 4'h9;
  localparam logic [3:0] OP_ADDI = 4'hA;
  localparam logic [3:0] OP_LW   = 4'hB;
  localparam logic [3:0] OP_SW   = 4'hC;
  localparam logic [3:0] OP_BEQ  = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   pc_r;
  logic [ADDR_W-1:0]   pc_next_r;
  logic [31:0]         ir_r;
  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic [DATA_W-1:0]   alu_r;
  logic [DATA_W-1:0]   mdr_r;
  logic [DATA_W-1:0]   regs_r [16];

  logic [3:0]          opcode_s;
  logic [3:0]          rd_s;
  logic [3:0]          rs1_s;
  logic [3:0]          rs2_s;
  logic [DATA_W-1:0]   imm_s;
  logic [SH_W-1:0]     shamt_s;
  logic [DATA_W-1:0]   alu_s;
  logic [ADDR_W-1:0]   next_pc_s;
  logic                is_mem_s;

  assign opcode_s = ir_r[31:28];
  assign rd_s     = ir_r[27:24];
  assign rs1_s    = ir_r[23:20];
  assign rs2_s    = ir_r[19:16];
  assign imm_s    = {{(DATA_W-16){ir_r[15]}}, ir_r[15:0]};
  assign shamt_s  = b_r[SH_W-1:0];
  assign is_mem_s = (opcode_s == OP_LW) || (opcode_s == OP_SW);
  assign pc_out   = pc_r;

  // r0 is never written, but the debug port forces 0 regardless.
  assign dbg_rdata = (dbg_raddr == 4'd0) ? {DATA_W{1'b0}} : regs_r[dbg_raddr];

  // ALU result; LW/SW share the A+imm adder for the effective address.
  always_comb begin
    alu_s = {DATA_W{1'b0}};
    case (opcode_s)
      OP_ADD:  alu_s = a_r + b_r;
      OP_SUB:  alu_s = a_r - b_r;
      OP_AND:  alu_s = a_r & b_r;
      OP_OR:   alu_s = a_r | b_r;
      OP_XOR:  alu_s = a_r ^ b_r;
      OP_NOT:  alu_s = ~a_r;
      OP_SHL:  alu_s = a_r << shamt_s;
      OP_SHR:  alu_s = a_r >> shamt_s;
      OP_SAR:  alu_s = $unsigned($signed(a_r) >>> shamt_s);
      OP_MUL:  alu_s = a_r * b_r;
      OP_ADDI: alu_s = a_r + imm_s;
      OP_LW:   alu_s = a_r + imm_s;
      OP_SW:   alu_s = a_r + imm_s;
      default: alu_s = {DATA_W{1'b0}};
    endcase
  end

  // Next PC: branch/jump target, HALT holds the PC, everything else PC+1 (wraps).
  always_comb begin
    next_pc_s = pc_r + ADDR_W'(1'b1);
    case (opcode_s)
      OP_BEQ: begin
        if (a_r == b_r) begin
          next_pc_s = pc_r + ADDR_W'(1'b1) + imm_s[ADDR_W-1:0];
        end else begin
          next_pc_s = pc_r + ADDR_W'(1'b1);
        end
      end
      OP_JMP:  next_pc_s = ADDR_W'(ir_r[15:0]);
      OP_HALT: next_pc_s = pc_r;
      default: next_pc_s = pc_r + ADDR_W'(1'b1);
    endcase
  end

  // Control FSM, datapath registers, register file and registered memory outputs.
  // mem_en is 0 out of reset, so the first FETCH cycle only raises the request;
  // later fetches are launched directly from WRITEBACK.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= S_FETCH;
      pc_r      <= {ADDR_W{1'b0}};
      pc_next_r <= {ADDR_W{1'b0}};
      ir_r      <= 32'd0;
      a_r       <= {DATA_W{1'b0}};
      b_r       <= {DATA_W{1'b0}};
      alu_r     <= {DATA_W{1'b0}};
      mdr_r     <= {DATA_W{1'b0}};
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      halted    <= 1'b0;
      instret   <= 32'd0;
      for (int i = 0; i < 16; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      case (state_r)
        S_FETCH: begin
          if (!mem_en) begin
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc_r;
          end else if (mem_ready) begin
            ir_r    <= mem_rdata[31:0];
            mem_en  <= 1'b0;
            state_r <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_r     <= regs_r[rs1_s];
          b_r     <= regs_r[rs2_s];
          state_r <= S_EXECUTE;
        end
        S_EXECUTE: begin
          alu_r     <= alu_s;
          pc_next_r <= next_pc_s;
          if (is_mem_s) begin
            mem_en   <= 1'b1;
            mem_we   <= (opcode_s == OP_SW);
            mem_addr <= alu_s[ADDR_W-1:0];
            if (opcode_s == OP_SW) begin
              mem_wdata <= b_r;
            end
            state_r  <= S_MEM;
          end else begin
            state_r  <= S_WRITEBACK;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (opcode_s == OP_LW) begin
              mdr_r <= mem_rdata;
            end
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            state_r <= S_WRITEBACK;
          end
        end
        S_WRITEBACK: begin
          if ((opcode_s <= OP_LW) && (rd_s != 4'd0)) begin
            regs_r[rd_s] <= (opcode_s == OP_LW) ? mdr_r : alu_r;
          end
          pc_r    <= pc_next_r;
          instret <= instret + 32'd1;
          if (opcode_s == OP_HALT) begin
            halted  <= 1'b1;
            state_r <= S_HALT;
          end else begin
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc_next_r;
            state_r  <= S_FETCH;
          end
        end
        S_HALT: begin
          state_r <= S_HALT;
        end
        default: begin
          state_r <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_multiciclo.sv
// Self-checking bench for cpu_multiciclo: table-driven ALU vectors, hand-written
// multi-cycle sequences and random programs checked against an ISA-level model.
module tb_cpu_multiciclo;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_en, mem_we, mem_ready, halted;
  logic [7:0]  mem_addr, pc_out;
  logic [31:0] mem_wdata, mem_rdata, instret, dbg_rdata;
  logic [3:0]  dbg_raddr;

  logic [31:0] mem_arr [256];
  int          waits [512];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc, started, req_idx, wait_cnt, n_stores, we_cyc;

  // reference model state
  logic [31:0] m_regs [16];
  logic [31:0] m_mem [256];
  logic [7:0]  m_pc;
  int          m_instret, m_cycles, m_stores, m_we;

  typedef struct {
    int          op;
    int          a;
    int          b;
    logic [31:0] exp;
  } alu_vec_t;
  alu_vec_t vecs [13];

  cpu_multiciclo #(.DATA_W(32), .ADDR_W(8)) dut (
    .clock(clock), .reset(reset), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .halted(halted), .pc_out(pc_out), .instret(instret),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clock = ~clock;
  assign mem_rdata = mem_arr[mem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1, input int rs2, input int imm);
    logic [31:0] w;
    w[31:28] = op[3:0];
    w[27:24] = rd[3:0];
    w[23:20] = rs1[3:0];
    w[19:16] = rs2[3:0];
    w[15:0]  = imm[15:0];
    return w;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem_arr[i] = 32'd0;
    for (int i = 0; i < 512; i++) waits[i] = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'b0;
    dbg_raddr = 4'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    cyc = 0; started = 0; req_idx = 0; wait_cnt = 0; n_stores = 0; we_cyc = 0;
  endtask

  // One clock cycle of the memory responder, decided at the falling edge.
  task automatic step();
    int w;
    @(negedge clock);
    if (!halted) begin
      if (mem_en) started = 1;
      if (started != 0) cyc++;
    end
    if (mem_en) begin
      if (mem_we) we_cyc++;
      w = (req_idx < 512) ? waits[req_idx] : 0;
      if (wait_cnt < w) begin
        mem_ready = 1'b0;
        wait_cnt++;
      end else begin
        mem_ready = 1'b1;
        if (mem_we) begin
          mem_arr[mem_addr] = mem_wdata;
          n_stores++;
        end
        req_idx++;
        wait_cnt = 0;
      end
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run_until_halt(input string name, input int max_c);
    int c = 0;
    while (!halted && c < max_c) begin
      step();
      c++;
    end
    n_cmp++;
    if (!halted) begin
      n_bad++;
      $display("FAIL %s_timeout: halted=%0b expected 1 within %0d cycles", name, halted, max_c);
    end
  endtask

  // ISA-level interpreter of the current memory image.
  task automatic model_run(input int max_instr);
    logic [31:0] ins, a, b, val, simm;
    logic [15:0] imm;
    logic [7:0]  nxt, ea;
    int          op, rd, sh, cost, widx;
    bit          wb, done;
    widx = 0; done = 0;
    for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
    for (int i = 0; i < 256; i++) m_mem[i] = mem_arr[i];
    m_pc = 8'd0; m_instret = 0; m_cycles = 0; m_stores = 0; m_we = 0;
    for (int n = 0; n < max_instr && !done; n++) begin
      ins  = m_mem[m_pc];
      op   = int'(ins[31:28]);
      rd   = int'(ins[27:24]);
      a    = m_regs[ins[23:20]];
      b    = m_regs[ins[19:16]];
      imm  = ins[15:0];
      simm = {{16{imm[15]}}, imm};
      sh   = int'(b % 32);
      cost = 4 + waits[widx];
      widx++;
      nxt  = m_pc + 8'd1;
      wb   = 1;
      val  = 32'd0;
      case (op)
        0:  val = a + b;
        1:  val = a - b;
        2:  val = a & b;
        3:  val = a | b;
        4:  val = a ^ b;
        5:  val = ~a;
        6:  val = a << sh;
        7:  val = a >> sh;
        8:  val = $unsigned($signed(a) >>> sh);
        9:  val = a * b;
        10: val = a + simm;
        11: begin
          ea = 8'((a + simm) % 256);
          val = m_mem[ea];
          cost += 1 + waits[widx];
          widx++;
        end
        12: begin
          ea = 8'((a + simm) % 256);
          m_mem[ea] = b;
          cost += 1 + waits[widx];
          m_we += 1 + waits[widx];
          widx++;
          m_stores++;
          wb = 0;
        end
        13: begin
          wb = 0;
          if (a == b) nxt = m_pc + 8'd1 + simm[7:0];
        end
        14: begin
          wb = 0;
          nxt = imm[7:0];
        end
        default: begin
          wb = 0;
          nxt = m_pc;
          done = 1;
        end
      endcase
      if (wb && rd != 0) m_regs[rd] = val;
      m_pc = nxt;
      m_instret++;
      m_cycles += cost;
    end
  endtask

  task automatic compare_model(input string name);
    int diffs = 0;
    check({name, "_instret"}, instret, 32'(m_instret));
    check({name, "_pc"}, {24'd0, pc_out}, {24'd0, m_pc});
    check({name, "_cycles"}, 32'(cyc), 32'(m_cycles));
    check({name, "_stores"}, 32'(n_stores), 32'(m_stores));
    check({name, "_we_cycles"}, 32'(we_cyc), 32'(m_we));
    for (int i = 0; i < 16; i++) begin
      dbg_raddr = 4'(i);
      #1;
      check($sformatf("%s_r%0d", name, i), dbg_rdata, m_regs[i]);
    end
    for (int i = 0; i < 256; i++) if (mem_arr[i] !== m_mem[i]) diffs++;
    check({name, "_mem_diffs"}, 32'(diffs), 32'd0);
  endtask

  task automatic run_prog(input string name, input int max_c);
    model_run(1000);
    do_reset();
    run_until_halt(name, max_c);
    compare_model(name);
  endtask

  task automatic read_reg(input int r, output logic [31:0] v);
    dbg_raddr = 4'(r);
    #1;
    v = dbg_rdata;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] i0;
    int          found;

    vecs[0]  = '{0,  5,      -3,    32'h0000_0002};
    vecs[1]  = '{1,  5,      7,     32'hFFFF_FFFE};
    vecs[2]  = '{2,  'h0F0F, 'h00FF, 32'h0000_000F};
    vecs[3]  = '{3,  'h0F00, 'h00F0, 32'h0000_0FF0};
    vecs[4]  = '{4,  'h0FF0, 'h00FF, 32'h0000_0F0F};
    vecs[5]  = '{5,  'h1234, 0,     32'hFFFF_EDCB};
    vecs[6]  = '{6,  1,      31,    32'h8000_0000};
    vecs[7]  = '{7,  -8,     1,     32'h7FFF_FFFC};
    vecs[8]  = '{8,  -8,     1,     32'hFFFF_FFFC};
    vecs[9]  = '{9,  -3,     7,     32'hFFFF_FFEB};
    vecs[10] = '{9,  'h7FFF, 'h7FFF, 32'h3FFF_0001};
    vecs[11] = '{6,  3,      33,    32'h0000_0006};
    vecs[12] = '{8,  -32768, 32,    32'hFFFF_8000};

    mem_ready = 1'b0;
    dbg_raddr = 4'd0;
    clear_mem();
    do_reset();
    reset = 1'b1;
    #2;
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_pc", {24'd0, pc_out}, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);

    // Table-driven ALU vectors: ADDI r1; ADDI r2; OP r3,r1,r2; HALT.
    for (int i = 0; i < 13; i++) begin
      clear_mem();
      mem_arr[0] = enc(10, 1, 0, 0, vecs[i].a);
      mem_arr[1] = enc(10, 2, 0, 0, vecs[i].b);
      mem_arr[2] = enc(vecs[i].op, 3, 1, 2, 0);
      mem_arr[3] = enc(15, 0, 0, 0, 0);
      run_prog($sformatf("alu%0d", i), 200);
      read_reg(3, v);
      check($sformatf("alu%0d_r3_const", i), v, vecs[i].exp);
      check($sformatf("alu%0d_cycles_const", i), 32'(cyc), 32'd16);
    end

    // Store then load with the data requests stalled 3 cycles each.
    clear_mem();
    mem_arr[0] = enc(10, 1, 0, 0, 'h1234);
    mem_arr[1] = enc(12, 0, 0, 1, 'h40);
    mem_arr[2] = enc(11, 5, 0, 0, 'h40);
    mem_arr[3] = enc(15, 0, 0, 0, 0);
    waits[2] = 3;
    waits[4] = 3;
    run_prog("swlw", 300);
    read_reg(5, v);
    check("swlw_r5_const", v, 32'h0000_1234);
    check("swlw_cycles_const", 32'(cyc), 32'd24);
    check("swlw_we_cycles_const", 32'(we_cyc), 32'd4);
    check("swlw_mem40_const", mem_arr[8'h40], 32'h0000_1234);

    // JMP to 0xFF, PC wraps to 0, branch falls through to HALT at 1.
    clear_mem();
    mem_arr[0]   = enc(13, 0, 1, 0, 1);
    mem_arr[1]   = enc(15, 0, 0, 0, 0);
    mem_arr[2]   = enc(14, 0, 0, 0, 'hFF);
    mem_arr[255] = enc(10, 1, 0, 0, 9);
    run_prog("wrap", 300);
    check("wrap_pc_const", {24'd0, pc_out}, 32'd1);
    check("wrap_instret_const", instret, 32'd5);

    // r0 write discarded.
    clear_mem();
    mem_arr[0] = enc(10, 1, 0, 0, 7);
    mem_arr[1] = enc(0, 0, 1, 1, 0);
    mem_arr[2] = enc(15, 0, 0, 0, 0);
    run_prog("r0", 200);
    read_reg(0, v);
    check("r0_const", v, 32'd0);

    // BEQ r0,r0,-1 at 0x10 loops forever; one retire per 4 cycles.
    clear_mem();
    mem_arr[0]    = enc(14, 0, 0, 0, 'h10);
    mem_arr[8'h10] = enc(13, 0, 0, 0, -1);
    do_reset();
    repeat (30) step();
    i0 = instret;
    repeat (4) step();
    check("loop_instret1", instret, i0 + 32'd1);
    check("loop_pc", {24'd0, pc_out}, 32'h10);
    repeat (4) step();
    check("loop_instret2", instret, i0 + 32'd2);
    check("loop_halted", {31'd0, halted}, 32'd0);

    // Reset during a stalled store: mem_en drops without a clock edge.
    clear_mem();
    mem_arr[0] = enc(10, 1, 0, 0, 'h55);
    mem_arr[1] = enc(12, 0, 0, 1, 'h40);
    mem_arr[2] = enc(15, 0, 0, 0, 0);
    waits[2] = 50;
    do_reset();
    found = 0;
    for (int c = 0; c < 40 && found == 0; c++) begin
      step();
      if (mem_we) found = 1;
    end
    check("rstsw_we_seen", 32'(found), 32'd1);
    repeat (2) step();
    #2;
    reset = 1'b1;
    #1;
    check("rstsw_mem_en_async", {31'd0, mem_en}, 32'd0);
    check("rstsw_mem_we_async", {31'd0, mem_we}, 32'd0);
    mem_arr[0] = enc(15, 0, 0, 0, 0);
    do_reset();
    check("rstsw_pc", {24'd0, pc_out}, 32'd0);
    check("rstsw_instret", instret, 32'd0);
    run_until_halt("rstsw", 50);
    check("rstsw_stores", 32'(n_stores), 32'd0);
    check("rstsw_mem40", mem_arr[8'h40], 32'd0);
    check("rstsw_instret_after", instret, 32'd1);

    // Random programs with random memory stalls.
    for (int p = 0; p < 6; p++) begin
      int pc, op;
      clear_mem();
      for (int i = 8'h80; i < 8'hA0; i++) mem_arr[i] = $urandom;
      for (int i = 0; i < 512; i++) waits[i] = $urandom_range(0, 2);
      pc = 0;
      for (int r = 1; r < 8; r++) begin
        mem_arr[pc] = enc(10, r, 0, 0, int'($urandom_range(0, 65535)));
        pc++;
      end
      for (int k = 0; k < 14; k++) begin
        op = $urandom_range(0, 13);
        if (op == 11 || op == 12)
          mem_arr[pc] = enc(op, $urandom_range(0, 7), 0, $urandom_range(0, 7), 'h80 + $urandom_range(0, 31));
        else if (op == 13)
          mem_arr[pc] = enc(13, 0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 2));
        else
          mem_arr[pc] = enc(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), int'($urandom_range(0, 65535)));
        pc++;
      end
      for (int h = 0; h < 3; h++) begin
        mem_arr[pc] = enc(15, 0, 0, 0, 0);
        pc++;
      end
      run_prog($sformatf("rnd%0d", p), 2000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
